sample_playback_fsm: RTL

Audio playback sequencer: the sample producer on the other end of the start/finish sample handshake used by the volume meter and other sample consumers. On a play request it reads 8-bit signed samples from a memory address range, attenuates each by a latched shift gain, and presents each one to the downstream consumer at the rate set by `sample_tick`. It sits between the sample memory (flash/ROM read port) and the audio consumer chain.

---
 rtl/audio_pkg.sv | 24 ++
 rtl/sample_attenuator.sv | 13 +
 rtl/vDFFE.sv | 20 ++
 rtl/sample_playback_fsm.sv | 117 +++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and widths for the sample playback path.
// The state encoding carries the decoded control outputs in its low four bits.
package audio_pkg;

  localparam int SAMPLE_W = 8;
  localparam int GAIN_W   = 3;
  localparam int STATE_W  = 7;

  localparam int BUSY_BIT     = 3;
  localparam int MEM_READ_BIT = 2;
  localparam int START_BIT    = 1;
  localparam int DONE_BIT     = 0;

  // {3-bit id, busy, mem_read, sample_start, done}
  typedef enum logic [STATE_W-1:0] {
    IDLE      = 7'b000_0000,
    FETCH     = 7'b001_1100,
    WAIT_TICK = 7'b010_1000,
    PRESENT   = 7'b011_1010,
    RELEASE   = 7'b100_1000,
    DONE      = 7'b101_1001
  } state_e;

endpackage

// File: rtl/sample_attenuator.sv
// Signed attenuation: arithmetic right shift keeps the sign, so large gains
// collapse negative samples to -1 and non-negative ones to 0.
module sample_attenuator
  import audio_pkg::*;
(
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic [GAIN_W-1:0]   shift,
  output logic [SAMPLE_W-1:0] sample_out
);

  assign sample_out = $signed(sample_in) >>> shift;

endmodule

// File: rtl/vDFFE.sv
// Enable flop with asynchronous active-high clear; the common register stage.
module vDFFE #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/sample_playback_fsm.sv
// Playback sequencer: fetches samples over an address range, attenuates them
// and hands each one to the consumer through the start/finish handshake.
module sample_playback_fsm
  import audio_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                play,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [ADDR_W-1:0]   end_addr,
  input  logic [GAIN_W-1:0]   gain,
  input  logic                sample_tick,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_read,
  input  logic [SAMPLE_W-1:0] mem_data,
  input  logic                mem_valid,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_start,
  input  logic                consumer_finish,
  output logic                busy,
  output logic                done,
  output logic                underrun
);

  state_e               state_q, state_d;
  logic [STATE_W-1:0]   state_bits_q;
  logic [ADDR_W-1:0]    addr_q, addr_d, end_q;
  logic [GAIN_W-1:0]    gain_q;
  logic [SAMPLE_W-1:0]  sample_q, atten_sample;
  logic                 underrun_q, underrun_d;
  logic                 addr_en, latch_en, sample_en;

  assign state_q = state_e'(state_bits_q);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    addr_en    = 1'b0;
    latch_en   = 1'b0;
    sample_en  = 1'b0;
    underrun_d = underrun_q;

    // A tick outside WAIT_TICK means the sample period is too short.
    if (sample_tick && (state_q == FETCH || state_q == PRESENT || state_q == RELEASE)) begin
      underrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (play) begin
          latch_en   = 1'b1;
          addr_d     = start_addr;
          addr_en    = 1'b1;
          underrun_d = 1'b0;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        if (mem_valid) begin
          sample_en = 1'b1;
          state_d   = WAIT_TICK;
        end
      end
      WAIT_TICK: begin
        if (sample_tick) state_d = PRESENT;
      end
      PRESENT: begin
        if (!consumer_finish) state_d = RELEASE;
      end
      RELEASE: begin
        if (consumer_finish) begin
          if (addr_q == end_q) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            addr_en = 1'b1;
            state_d = FETCH;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort wins over everything and leaves the presented sample untouched.
    if (abort && state_q != IDLE) begin
      state_d   = IDLE;
      addr_en   = 1'b0;
      sample_en = 1'b0;
    end
  end

  vDFFE #(.N(STATE_W))  u_state    (.clk(clk), .reset(reset), .en(1'b1),      .d(state_d),      .q(state_bits_q));
  vDFFE #(.N(ADDR_W))   u_addr     (.clk(clk), .reset(reset), .en(addr_en),   .d(addr_d),       .q(addr_q));
  vDFFE #(.N(ADDR_W))   u_end      (.clk(clk), .reset(reset), .en(latch_en),  .d(end_addr),     .q(end_q));
  vDFFE #(.N(GAIN_W))   u_gain     (.clk(clk), .reset(reset), .en(latch_en),  .d(gain),         .q(gain_q));
  vDFFE #(.N(SAMPLE_W)) u_sample   (.clk(clk), .reset(reset), .en(sample_en), .d(atten_sample), .q(sample_q));
  vDFFE #(.N(1))        u_underrun (.clk(clk), .reset(reset), .en(1'b1),      .d(underrun_d),   .q(underrun_q));

  sample_attenuator u_atten (
    .sample_in  (mem_data),
    .shift      (gain_q),
    .sample_out (atten_sample)
  );

  assign mem_addr     = addr_q;
  assign sample_out   = sample_q;
  assign underrun     = underrun_q;
  assign busy         = state_bits_q[BUSY_BIT];
  assign mem_read     = state_bits_q[MEM_READ_BIT];
  assign sample_start = state_bits_q[START_BIT];
  assign done         = state_bits_q[DONE_BIT];

endmodule
